// File: rtl/sec_tick_gen.sv
// Front end for the seconds counter: 1 Hz srco tick, debounced run/stop toggle (enp)
// and a stretched active-low clear (clrn). All outputs come straight from flops.
module sec_tick_gen #(
    parameter int DIV       = 50000000,
    parameter int DB_CYCLES = 1000000,
    parameter int CLR_HOLD  = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_run,
    input  logic btn_clr,
    output logic srco,
    output logic enp,
    output logic clrn
);

    localparam int PW  = $clog2(DIV);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(CLR_HOLD + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state, state_next;
    logic [1:0]     sync1, sync2, stable, stable_q;
    logic [DBW-1:0] db_cnt [2];
    logic [PW-1:0]  presc, presc_next;
    logic [HW-1:0]  hold, hold_next;
    logic           srco_next, clrn_next;
    logic           run_p, clr_p, clearing;

    // Bit 0 is the run button, bit 1 the clear button; both share the same
    // synchroniser and debounce structure.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1    <= {btn_clr, btn_run};
            sync2    <= sync1;
            stable_q <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign run_p = stable[0] & ~stable_q[0];
    assign clr_p = stable[1] & ~stable_q[1];

    always_comb begin
        state_next = state;
        hold_next  = hold;
        presc_next = presc;
        srco_next  = 1'b0;

        if (run_p) state_next = (state == IDLE) ? RUN : IDLE;

        if (clr_p)
            hold_next = HW'(CLR_HOLD);
        else if (hold != '0)
            hold_next = hold - 1'b1;

        // The cycle carrying clr_p already counts as part of the hold, so the
        // prescaler restarts cleanly from zero when clrn returns high.
        clearing = clr_p || (hold != '0);

        if (clearing)
            presc_next = '0;
        else if (state == RUN)
            presc_next = (presc == PW'(DIV - 1)) ? '0 : presc + 1'b1;

        srco_next = (state == RUN) && !clearing && (presc == PW'(DIV - 1));
        clrn_next = (hold_next == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            presc <= '0;
            hold  <= '0;
            srco  <= 1'b0;
            clrn  <= 1'b0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            hold  <= hold_next;
            srco  <= srco_next;
            clrn  <= clrn_next;
        end
    end

    assign enp = (state == RUN);

endmodule

// File: tb/tb_sec_tick_gen.sv
// Directed bench for sec_tick_gen with DIV=10, DB_CYCLES=4, CLR_HOLD=3; edge-numbered
// event times from a negedge monitor are compared against hand-derived latencies.
module tb_sec_tick_gen;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic btn_run = 1'b0;
    logic btn_clr = 1'b0;
    logic srco, enp, clrn;

    int check_cnt = 0;
    int pass_cnt  = 0;

    int cyc = 0;
    int srco_cnt = 0, srco_wide = 0, srco_in_hold = 0, clrn_low_cnt = 0;
    int enp_rise_cyc = -1, enp_fall_cyc = -1, clrn_fall_cyc = -1, clrn_rise_cyc = -1;
    int srco_q[$];
    logic srco_prev = 1'b0, enp_prev = 1'b0, clrn_prev = 1'b0;
    int t0, rise, rise2;

    sec_tick_gen #(.DIV(10), .DB_CYCLES(4), .CLR_HOLD(3)) dut (
        .clk     (clk),
        .clr     (clr),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .srco    (srco),
        .enp     (enp),
        .clrn    (clrn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records the edge number after which each output event became visible.
    always @(negedge clk) begin
        if (srco) begin
            srco_cnt++;
            srco_q.push_back(cyc);
            if (srco_prev) srco_wide++;
            if (!clrn) srco_in_hold++;
        end
        if (!clrn) clrn_low_cnt++;
        if (enp && !enp_prev) enp_rise_cyc = cyc;
        if (!enp && enp_prev) enp_fall_cyc = cyc;
        if (!clrn && clrn_prev) clrn_fall_cyc = cyc;
        if (clrn && !clrn_prev) clrn_rise_cyc = cyc;
        srco_prev = srco;
        enp_prev  = enp;
        clrn_prev = clrn;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_cnt++;
        if (actual == expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic run, input logic clrb, input int n);
        btn_run = run;
        btn_clr = clrb;
        repeat (n) step();
    endtask

    function automatic int qAt(input int i);
        return (i < srco_q.size()) ? srco_q[i] : -1000;
    endfunction

    initial begin
        #1 clr = 1'b1;
        repeat (3) step();
        checkOutput("reset_srco", srco, 0);
        checkOutput("reset_enp", enp, 0);
        checkOutput("reset_clrn", clrn, 0);
        clr = 1'b0;
        checkOutput("release_clrn_before_edge", clrn, 0);
        step();
        checkOutput("release_clrn", clrn, 1);
        checkOutput("release_enp", enp, 0);
        srco_cnt = 0;
        applyStimulus(0, 0, 50);
        checkOutput("idle_no_srco", srco_cnt, 0);
        checkOutput("idle_enp", enp, 0);

        // Short press must be rejected, a long one toggles enp after 2+4+1 edges.
        applyStimulus(1, 0, 3);
        applyStimulus(0, 0, 10);
        checkOutput("short_press_enp", enp, 0);
        checkOutput("short_press_no_rise", enp_rise_cyc, -1);
        t0 = cyc;
        srco_q.delete();
        srco_wide = 0;
        applyStimulus(1, 0, 10);
        checkOutput("press_enp", enp, 1);
        checkOutput("press_latency", enp_rise_cyc - t0, 7);
        rise = enp_rise_cyc;
        applyStimulus(0, 0, 1);
        while (cyc < rise + 105) step();
        checkOutput("tick_count", srco_q.size(), 10);
        checkOutput("first_tick", qAt(0) - rise, 10);
        for (int i = 1; i < 10; i++)
            checkOutput($sformatf("tick_gap_%0d", i), qAt(i) - qAt(i - 1), 10);
        checkOutput("tick_width", srco_wide, 0);

        // Stop so that the prescaler holds 6, then resume: tick 4 edges later.
        while (cyc < rise + 109) step();
        applyStimulus(1, 0, 10);
        checkOutput("stop_enp", enp, 0);
        checkOutput("stop_edge", enp_fall_cyc - rise, 116);
        applyStimulus(0, 0, 1);
        srco_cnt = 0;
        applyStimulus(0, 0, 30);
        checkOutput("pause_no_srco", srco_cnt, 0);
        t0 = cyc;
        srco_q.delete();
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 5);
        checkOutput("resume_enp", enp, 1);
        checkOutput("resume_latency", enp_rise_cyc - t0, 7);
        checkOutput("resume_tick", qAt(0) - enp_rise_cyc, 4);

        // Clear press timed so a natural tick would coincide with the first hold cycle.
        rise2 = enp_rise_cyc;
        while (cyc < rise2 + 17) step();
        t0 = cyc;
        clrn_low_cnt = 0;
        srco_in_hold = 0;
        applyStimulus(0, 1, 10);
        srco_q.delete();
        applyStimulus(0, 0, 15);
        checkOutput("clear_low_cycles", clrn_low_cnt, 3);
        checkOutput("clear_fall_edge", clrn_fall_cyc - t0, 7);
        checkOutput("clear_rise_edge", clrn_rise_cyc - t0, 10);
        checkOutput("clear_no_srco", srco_in_hold, 0);
        checkOutput("clear_enp", enp, 1);
        checkOutput("clear_next_tick", qAt(0) - clrn_rise_cyc, 10);

        applyStimulus(0, 0, 10);
        t0 = cyc;
        clrn_low_cnt = 0;
        applyStimulus(1, 1, 10);
        checkOutput("both_enp", enp, 0);
        checkOutput("both_enp_edge", enp_fall_cyc - t0, 7);
        checkOutput("both_clrn_edge", clrn_fall_cyc - t0, 7);
        checkOutput("both_low_cycles", clrn_low_cnt, 3);
        applyStimulus(0, 0, 20);
        t0 = cyc;
        srco_q.delete();
        applyStimulus(1, 0, 10);
        applyStimulus(0, 0, 10);
        checkOutput("both_resume_enp", enp, 1);
        checkOutput("both_presc_zero", qAt(0) - enp_rise_cyc, 10);

        // Asynchronous reset in the middle of a cycle while running and debouncing.
        applyStimulus(0, 0, 20);
        applyStimulus(1, 0, 4);
        #2 clr = 1'b1;
        #1;
        checkOutput("async_srco", srco, 0);
        checkOutput("async_enp", enp, 0);
        checkOutput("async_clrn", clrn, 0);
        step();
        clr = 1'b0;
        t0 = cyc;
        applyStimulus(1, 0, 10);
        checkOutput("async_clrn_rise", clrn_rise_cyc - t0, 1);
        checkOutput("async_enp_after", enp, 1);
        checkOutput("async_redebounce", enp_rise_cyc - t0, 7);
        applyStimulus(0, 0, 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
